// File: rtl/serial_sub_ctrl.sv
// Bit-serial unsigned subtractor controller.
// A single 1-bit borrow datapath, built from two half-subtractors, processes
// one bit per clock, LSB first. diff/bo update only when the DONE state is
// entered, so they never show partial results.
module serial_sub_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bo
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res_sh;
  logic [WIDTH-1:0] res_next;
  logic [CW-1:0]    cnt;
  logic             bin;

  logic a_i, b_i, d1, b1, d_i, b2, bout;

  // One-bit subtract of the current LSBs against the stored borrow
  always_comb begin
    a_i      = a_sh[0];
    b_i      = b_sh[0];
    d1       = a_i ^ b_i;
    b1       = ~a_i & b_i;
    d_i      = d1 ^ bin;
    b2       = ~d1 & bin;
    bout     = b1 | b2;
    res_next = {d_i, res_sh[WIDTH-1:1]};
  end

  // Control FSM, operand/result shifting and result publication
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      a_sh   <= '0;
      b_sh   <= '0;
      res_sh <= '0;
      cnt    <= '0;
      bin    <= 1'b0;
      diff   <= '0;
      bo     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sh   <= a;
            b_sh   <= b;
            res_sh <= '0;
            cnt    <= '0;
            bin    <= 1'b0;
            state  <= RUN;
          end
        end
        RUN: begin
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          res_sh <= res_next;
          bin    <= bout;
          if (cnt == LAST) begin
            cnt   <= '0;
            diff  <= res_next;
            bo    <= bout;
            state <= DONE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Status outputs decode directly from the registered state
  assign busy = (state == RUN);
  assign done = (state == DONE);

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Directed bench for serial_sub_ctrl with a WIDTH=8 and a WIDTH=16 instance.
module tb_serial_sub_ctrl;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        busy;
  logic        done;
  logic [7:0]  diff;
  logic        bo;

  logic        start16;
  logic [15:0] a16;
  logic [15:0] b16;
  logic        busy16;
  logic        done16;
  logic [15:0] diff16;
  logic        bo16;

  int checks;
  int errors;

  serial_sub_ctrl #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .diff(diff), .bo(bo)
  );

  serial_sub_ctrl #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .start(start16), .a(a16), .b(b16),
    .busy(busy16), .done(done16), .diff(diff16), .bo(bo16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle just after it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Run one 8-bit operation from IDLE; returns results, latency and busy count
  task automatic do_op8(input logic [7:0] av, input logic [7:0] bv,
                        output logic [7:0] d, output logic o,
                        output int lat, output int bcnt, output bit tmo);
    a = av;
    b = bv;
    start = 1'b1;
    tick();
    start = 1'b0;
    lat = 0;
    bcnt = 0;
    while (!done && lat < 40) begin
      if (busy) bcnt++;
      tick();
      lat++;
    end
    tmo = !done;
    d = diff;
    o = bo;
    tick();
  endtask

  // Run one 16-bit operation from IDLE
  task automatic do_op16(input logic [15:0] av, input logic [15:0] bv,
                         output logic [15:0] d, output logic o, output bit tmo);
    int cyc;
    a16 = av;
    b16 = bv;
    start16 = 1'b1;
    tick();
    start16 = 1'b0;
    cyc = 0;
    while (!done16 && cyc < 60) begin
      tick();
      cyc++;
    end
    tmo = !done16;
    d = diff16;
    o = bo16;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b1;
    a = 8'd33;
    b = 8'd11;
    tick();
    tick();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || diff !== 8'd0 || bo !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_state busy=%b done=%b diff=%0d bo=%b expected 0/0/0/0",
               busy, done, diff, bo);
    end
    checks++;
    if (busy16 !== 1'b0 || done16 !== 1'b0 || diff16 !== 16'd0 || bo16 !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_state16 busy=%b done=%b diff=%0d bo=%b expected 0/0/0/0",
               busy16, done16, diff16, bo16);
    end
  endtask

  task automatic test_first_start();
    int cyc;
    a = 8'd12;
    b = 8'd2;
    start = 1'b1;
    rst_n = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL first_start_accept busy=%b expected 1", busy);
    end
    cyc = 0;
    while (!done && cyc < 40) begin
      tick();
      cyc++;
    end
    checks++;
    if (done !== 1'b1 || diff !== 8'd10 || bo !== 1'b0) begin
      errors++;
      $display("[TB] FAIL first_start_result done=%b diff=%0d bo=%b expected 1/10/0",
               done, diff, bo);
    end
    tick();
  endtask

  task automatic test_basic();
    logic [7:0] d;
    logic o;
    int lat, bcnt;
    bit tmo;
    do_op8(8'd200, 8'd55, d, o, lat, bcnt, tmo);
    checks++;
    if (tmo || d !== 8'd145 || o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL basic_200_55 diff=%0d bo=%b timeout=%0d expected 145/0/0", d, o, tmo);
    end
    checks++;
    if (lat != 8) begin
      errors++;
      $display("[TB] FAIL basic_latency got %0d cycles expected 8", lat);
    end
    checks++;
    if (bcnt != 8) begin
      errors++;
      $display("[TB] FAIL basic_busy_cycles got %0d expected 8", bcnt);
    end
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL done_single_pulse done=%b busy=%b expected 0/0", done, busy);
    end
  endtask

  task automatic test_vectors();
    logic [7:0] va [5] = '{8'd5, 8'd0, 8'd0, 8'd77, 8'd0};
    logic [7:0] vb [5] = '{8'd10, 8'd1, 8'd0, 8'd77, 8'd255};
    logic [7:0] vd [5] = '{8'd251, 8'd255, 8'd0, 8'd0, 8'd1};
    logic       vo [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    logic [7:0] d;
    logic o;
    int lat, bcnt;
    bit tmo;
    for (int i = 0; i < 5; i++) begin
      do_op8(va[i], vb[i], d, o, lat, bcnt, tmo);
      checks++;
      if (tmo || d !== vd[i] || o !== vo[i]) begin
        errors++;
        $display("[TB] FAIL vector_%0d_%0d diff=%0d bo=%b timeout=%0d expected %0d/%b",
                 va[i], vb[i], d, o, tmo, vd[i], vo[i]);
      end
    end
  endtask

  task automatic test_hold();
    logic [7:0] d;
    logic o;
    int lat, bcnt;
    bit tmo;
    do_op8(8'd200, 8'd55, d, o, lat, bcnt, tmo);
    a = 8'd5;
    b = 8'd10;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    checks++;
    if (diff !== 8'd145 || bo !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL hold_during_run diff=%0d bo=%b busy=%b expected 145/0/1", diff, bo, busy);
    end
    for (int i = 0; i < 20 && !done; i++) tick();
    tick();
  endtask

  task automatic test_ignore_start();
    int pulses;
    int cyc;
    a = 8'd100;
    b = 8'd1;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    a = 8'd0;
    b = 8'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    pulses = 0;
    cyc = 0;
    while (cyc < 25) begin
      if (done) begin
        pulses++;
        checks++;
        if (diff !== 8'd99 || bo !== 1'b0) begin
          errors++;
          $display("[TB] FAIL ignore_start_result diff=%0d bo=%b expected 99/0", diff, bo);
        end
      end
      tick();
      cyc++;
    end
    checks++;
    if (pulses != 1) begin
      errors++;
      $display("[TB] FAIL ignore_start_pulses got %0d expected 1", pulses);
    end
  endtask

  task automatic test_reset_mid_run();
    int pulses;
    logic [7:0] d;
    logic o;
    int lat, bcnt;
    bit tmo;
    a = 8'd50;
    b = 8'd20;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || diff !== 8'd0 || bo !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_mid_run busy=%b done=%b diff=%0d bo=%b expected 0/0/0/0",
               busy, done, diff, bo);
    end
    rst_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      if (done || busy) pulses++;
      tick();
    end
    checks++;
    if (pulses != 0) begin
      errors++;
      $display("[TB] FAIL reset_abort_activity got %0d active cycles expected 0", pulses);
    end
    do_op8(8'd9, 8'd3, d, o, lat, bcnt, tmo);
    checks++;
    if (tmo || d !== 8'd6 || o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL after_reset_9_3 diff=%0d bo=%b timeout=%0d expected 6/0", d, o, tmo);
    end
  endtask

  task automatic test_back_to_back();
    int t [2];
    logic [7:0] rd [2];
    logic ro [2];
    int n;
    int cyc;
    a = 8'd7;
    b = 8'd3;
    start = 1'b1;
    n = 0;
    cyc = 0;
    while (n < 2 && cyc < 60) begin
      tick();
      cyc++;
      if (done) begin
        t[n] = cyc;
        rd[n] = diff;
        ro[n] = bo;
        n++;
        a = 8'd3;
        b = 8'd7;
        if (n == 2) start = 1'b0;
      end
    end
    start = 1'b0;
    checks++;
    if (n != 2) begin
      errors++;
      $display("[TB] FAIL b2b_pulses got %0d expected 2", n);
    end else begin
      checks++;
      if (t[1] - t[0] != 10) begin
        errors++;
        $display("[TB] FAIL b2b_spacing got %0d expected 10", t[1] - t[0]);
      end
      checks++;
      if (rd[0] !== 8'd4 || ro[0] !== 1'b0 || rd[1] !== 8'd252 || ro[1] !== 1'b1) begin
        errors++;
        $display("[TB] FAIL b2b_results got %0d/%b %0d/%b expected 4/0 252/1",
                 rd[0], ro[0], rd[1], ro[1]);
      end
    end
    tick();
    tick();
  endtask

  task automatic test_random8();
    logic [7:0] ra, rb, d, ed;
    logic o, eo;
    int lat, bcnt;
    bit tmo;
    for (int i = 0; i < 1000; i++) begin
      ra = 8'($urandom_range(255));
      rb = 8'($urandom_range(255));
      ed = ra - rb;
      eo = (ra < rb);
      do_op8(ra, rb, d, o, lat, bcnt, tmo);
      checks++;
      if (tmo || d !== ed || o !== eo) begin
        errors++;
        $display("[TB] FAIL random8 a=%0d b=%0d diff=%0d bo=%b expected %0d/%b",
                 ra, rb, d, o, ed, eo);
      end
    end
  endtask

  task automatic test_random16();
    logic [15:0] ra, rb, d, ed;
    logic o, eo;
    bit tmo;
    for (int i = 0; i < 1000; i++) begin
      ra = 16'($urandom_range(65535));
      rb = 16'($urandom_range(65535));
      ed = ra - rb;
      eo = (ra < rb);
      do_op16(ra, rb, d, o, tmo);
      checks++;
      if (tmo || d !== ed || o !== eo) begin
        errors++;
        $display("[TB] FAIL random16 a=%0d b=%0d diff=%0d bo=%b expected %0d/%b",
                 ra, rb, d, o, ed, eo);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    start = 1'b0;
    a = '0;
    b = '0;
    start16 = 1'b0;
    a16 = '0;
    b16 = '0;
    test_reset();
    test_first_start();
    test_basic();
    test_vectors();
    test_hold();
    test_ignore_start();
    test_reset_mid_run();
    test_back_to_back();
    test_random8();
    test_random16();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
